// File: rtl/dncnt_pkg.sv
// Shared types for the loadable down counter/timer.
// Provides the FSM state enum and the zero-count constant.
package dncnt_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } dncnt_state_e;

    // Terminal value of the count; widened to WIDTH where it is used.
    localparam int unsigned DNCNT_ZERO = 0;

    // Count value on which the next tick is the terminal tick.
    localparam int unsigned DNCNT_LAST = 1;

endpackage

// File: rtl/dncnt_prescaler.sv
// Tick divider: one tick every div+1 cycles with en=1 (div=0 -> tick=en).
// Ports: clk, reset (async high), clr (restart), en, div -> tick.
module dncnt_prescaler #(
    parameter int PRESCALE_W = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clr,
    input  logic                  en,
    input  logic [PRESCALE_W-1:0] div,
    output logic                  tick
);

    logic [PRESCALE_W-1:0] cnt;

    // >= rather than == so a divider lowered mid-count cannot
    // leave the counter stranded above the new terminal value.
    assign tick = en & (cnt >= div);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else begin
            unique case (1'b1)
                clr:     cnt <= '0;
                tick:    cnt <= '0;
                en:      cnt <= cnt + 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/down_counter_timer.sv
// Loadable WIDTH-bit down counter/timer with one-shot and auto-reload
// modes, one-cycle tc_pulse strobe and abort.
// Ports: clk, reset (async high), load_valid/load_ready handshake with
// load_value/auto_reload, enable, abort, prescale_div (macro only)
// -> count_out, busy, tc_pulse, done.
// Optional feature: define DNCNT_PRESCALE_EN to add the tick prescaler.
module down_counter_timer
    import dncnt_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int PRESCALE_W = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load_valid,
    output logic                  load_ready,
    input  logic [WIDTH-1:0]      load_value,
    input  logic                  auto_reload,
    input  logic                  enable,
    input  logic                  abort,
`ifdef DNCNT_PRESCALE_EN
    input  logic [PRESCALE_W-1:0] prescale_div,
`endif
    output logic [WIDTH-1:0]      count_out,
    output logic                  busy,
    output logic                  tc_pulse,
    output logic                  done
);

    localparam logic [WIDTH-1:0] CNT_ZERO = WIDTH'(DNCNT_ZERO);
    localparam logic [WIDTH-1:0] CNT_LAST = WIDTH'(DNCNT_LAST);

    dncnt_state_e     state;
    logic [WIDTH-1:0] reload_reg;
    logic             mode;

    logic in_run;
    logic accept;
    logic tick;
    logic run_tick;
    logic zero_load;
    logic last_tick;

    assign in_run     = (state == RUN);
    assign load_ready = ~in_run & ~abort;
    assign accept     = load_valid & load_ready;
    assign zero_load  = (load_value == CNT_ZERO);
    assign last_tick  = (count_out == CNT_LAST);

`ifdef DNCNT_PRESCALE_EN
    dncnt_prescaler #(
        .PRESCALE_W (PRESCALE_W)
    ) u_prescaler (
        .clk   (clk),
        .reset (reset),
        .clr   (accept | abort),
        .en    (enable & in_run),
        .div   (prescale_div),
        .tick  (tick)
    );
`else
    logic [PRESCALE_W-1:0] unused_prescale;
    assign unused_prescale = '0;
    assign tick            = enable;
`endif

    // abort gates run_tick so the decode below is one-hot:
    // accept already excludes abort and RUN.
    assign run_tick = in_run & tick & ~abort;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            count_out  <= CNT_ZERO;
            reload_reg <= CNT_ZERO;
            mode       <= 1'b0;
            tc_pulse   <= 1'b0;
            done       <= 1'b0;
            busy       <= 1'b0;
        end else begin
            tc_pulse <= 1'b0;
            unique case (1'b1)
                abort: begin
                    state     <= IDLE;
                    count_out <= CNT_ZERO;
                    done      <= 1'b0;
                    busy      <= 1'b0;
                end
                accept: begin
                    if (zero_load) begin
                        // Zero load is an immediate terminal event.
                        state     <= DONE;
                        count_out <= CNT_ZERO;
                        tc_pulse  <= 1'b1;
                        done      <= 1'b1;
                        busy      <= 1'b0;
                    end else begin
                        state      <= RUN;
                        count_out  <= load_value;
                        reload_reg <= load_value;
                        mode       <= auto_reload;
                        done       <= 1'b0;
                        busy       <= 1'b1;
                    end
                end
                run_tick: begin
                    if (!last_tick) begin
                        count_out <= count_out - 1'b1;
                    end else if (mode) begin
                        // Reload instead of showing 0: period = reload_reg.
                        count_out <= reload_reg;
                        tc_pulse  <= 1'b1;
                    end else begin
                        state     <= DONE;
                        count_out <= CNT_ZERO;
                        tc_pulse  <= 1'b1;
                        done      <= 1'b1;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state <= state;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_down_counter_timer.sv
// Directed scoreboard bench for down_counter_timer.
// Expected outputs are queued per step and popped after each clock.
module tb_down_counter_timer;

    logic       clk;
    logic       reset;
    logic       load_valid;
    logic       load_ready;
    logic [7:0] load_value;
    logic       auto_reload;
    logic       enable;
    logic       abort;
    logic [7:0] count_out;
    logic       busy;
    logic       tc_pulse;
    logic       done;
`ifdef DNCNT_PRESCALE_EN
    logic [3:0] prescale_div;
`endif

    typedef struct packed {
        logic [7:0] cnt;
        logic       bsy;
        logic       dn;
        logic       tc;
        logic       rdy;
    } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_pass = 0;
    int   n_fail = 0;

    down_counter_timer #(
        .WIDTH      (8),
        .PRESCALE_W (4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .load_valid   (load_valid),
        .load_ready   (load_ready),
        .load_value   (load_value),
        .auto_reload  (auto_reload),
        .enable       (enable),
        .abort        (abort),
`ifdef DNCNT_PRESCALE_EN
        .prescale_div (prescale_div),
`endif
        .count_out    (count_out),
        .busy         (busy),
        .tc_pulse     (tc_pulse),
        .done         (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] c, input logic b, input logic d,
                        input logic t, input logic r);
        exp_t e;
        e.cnt = c;
        e.bsy = b;
        e.dn  = d;
        e.tc  = t;
        e.rdy = r;
        sb.push_back(e);
    endtask

    task automatic pop_chk(input string tag);
        exp_t e;
        n_chk++;
        assert (sb.size() > 0) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s_sb: observed empty expected entry", tag);
        end
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk({tag, "_cnt"},  32'(count_out),  32'(e.cnt));
            chk({tag, "_busy"}, 32'(busy),       32'(e.bsy));
            chk({tag, "_done"}, 32'(done),       32'(e.dn));
            chk({tag, "_tc"},   32'(tc_pulse),   32'(e.tc));
            chk({tag, "_rdy"},  32'(load_ready), 32'(e.rdy));
        end
    endtask

    // Drive one cycle of inputs, queue the expected post-edge outputs,
    // then sample 1 time unit after the edge.
    task automatic cyc(input logic lv, input logic [7:0] lval,
                       input logic ar, input logic en, input logic ab,
                       input logic [7:0] c, input logic b, input logic d,
                       input logic t, input logic r, input string tag);
        load_valid  = lv;
        load_value  = lval;
        auto_reload = ar;
        enable      = en;
        abort       = ab;
        push(c, b, d, t, r);
        @(posedge clk);
        #1;
        pop_chk(tag);
    endtask

    initial begin
        reset       = 1'b1;
        load_valid  = 1'b0;
        load_value  = 8'd0;
        auto_reload = 1'b0;
        enable      = 1'b0;
        abort       = 1'b0;
`ifdef DNCNT_PRESCALE_EN
        prescale_div = 4'd0;
`endif
        repeat (2) @(posedge clk);
        #1;
        push(8'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        pop_chk("rst");
        reset = 1'b0;

        // One-shot count 3,2,1,0
        cyc(1, 8'd3, 0, 0, 0, 8'd3, 1, 0, 0, 0, "os_ld");
        cyc(0, 8'd0, 0, 1, 0, 8'd2, 1, 0, 0, 0, "os_2");
        cyc(0, 8'd0, 0, 1, 0, 8'd1, 1, 0, 0, 0, "os_1");
        cyc(0, 8'd0, 0, 1, 0, 8'd0, 0, 1, 1, 1, "os_0");
        cyc(0, 8'd0, 0, 0, 0, 8'd0, 0, 1, 0, 1, "os_hold");

        // Auto-reload period 2, loaded from DONE
        cyc(1, 8'd2, 1, 1, 0, 8'd2, 1, 0, 0, 0, "ar_ld");
        for (int i = 0; i < 5; i++) begin
            if (i % 2 == 0)
                cyc(0, 8'd0, 0, 1, 0, 8'd1, 1, 0, 0, 0, "ar_1");
            else
                cyc(0, 8'd0, 0, 1, 0, 8'd2, 1, 0, 1, 0, "ar_2");
        end
        cyc(0, 8'd0, 0, 0, 1, 8'd0, 0, 0, 0, 0, "ar_abort");
        cyc(0, 8'd0, 0, 0, 0, 8'd0, 0, 0, 0, 1, "ar_idle");

        // Pause and abort on a terminal tick
        cyc(1, 8'd4, 0, 0, 0, 8'd4, 1, 0, 0, 0, "pa_ld");
        cyc(0, 8'd0, 0, 1, 0, 8'd3, 1, 0, 0, 0, "pa_3");
        cyc(0, 8'd0, 0, 0, 0, 8'd3, 1, 0, 0, 0, "pa_hold");
        cyc(0, 8'd0, 0, 1, 0, 8'd2, 1, 0, 0, 0, "pa_2");
        cyc(0, 8'd0, 0, 1, 0, 8'd1, 1, 0, 0, 0, "pa_1");
        cyc(0, 8'd0, 0, 1, 1, 8'd0, 0, 0, 0, 0, "pa_abort");
        cyc(0, 8'd0, 0, 0, 0, 8'd0, 0, 0, 0, 1, "pa_idle");

        // Asynchronous reset in the middle of a run
        cyc(1, 8'd5, 0, 0, 0, 8'd5, 1, 0, 0, 0, "rr_ld");
        load_valid = 1'b0;
        reset      = 1'b1;
        #1;
        push(8'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        pop_chk("rr_async");
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Zero load, then loads offered while busy
        cyc(1, 8'd0, 0, 0, 0, 8'd0, 0, 1, 1, 1, "zl_ld");
        cyc(0, 8'd0, 0, 0, 0, 8'd0, 0, 1, 0, 1, "zl_after");
        cyc(1, 8'd0, 1, 0, 0, 8'd0, 0, 1, 1, 1, "zl_ar");
        cyc(1, 8'd6, 0, 0, 0, 8'd6, 1, 0, 0, 0, "bl_ld");
        cyc(1, 8'd9, 0, 1, 0, 8'd5, 1, 0, 0, 0, "bl_tick");
        cyc(1, 8'd9, 0, 0, 0, 8'd5, 1, 0, 0, 0, "bl_hold");
        cyc(1, 8'd7, 0, 0, 1, 8'd0, 0, 0, 0, 0, "bl_abort");
        cyc(1, 8'd7, 0, 0, 1, 8'd0, 0, 0, 0, 0, "ab_ld_idle");
        cyc(0, 8'd0, 0, 0, 0, 8'd0, 0, 0, 0, 1, "ab_idle");

`ifdef DNCNT_PRESCALE_EN
        prescale_div = 4'd2;
        cyc(1, 8'd2, 0, 1, 0, 8'd2, 1, 0, 0, 0, "ps_ld");
        cyc(0, 8'd0, 0, 1, 0, 8'd2, 1, 0, 0, 0, "ps_c1");
        cyc(0, 8'd0, 0, 1, 0, 8'd2, 1, 0, 0, 0, "ps_c2");
        cyc(0, 8'd0, 0, 1, 0, 8'd1, 1, 0, 0, 0, "ps_c3");
        cyc(0, 8'd0, 0, 1, 0, 8'd1, 1, 0, 0, 0, "ps_c4");
        cyc(0, 8'd0, 0, 1, 0, 8'd1, 1, 0, 0, 0, "ps_c5");
        cyc(0, 8'd0, 0, 1, 0, 8'd0, 0, 1, 1, 1, "ps_c6");
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
